// File: rtl/lifo.sv
// Synchronous LIFO stack of DEPTH words with a registered pop output.
// Simultaneous push/pop replaces the top word, or bypasses data_in when the stack is empty.
module lifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [DATA_WIDTH-1:0]        data_in,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [CW-1:0]         sp_q, sp_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [CW-1:0]         sp_dec;
    logic [AW-1:0]         top_addr;
    logic                  full_w, empty_w;

    assign full_w   = (sp_q == DEPTH_C);
    assign empty_w  = (sp_q == '0);
    assign sp_dec   = sp_q - CW'(1);
    assign top_addr = sp_dec[AW-1:0];

    always_comb begin
        sp_d        = sp_q;
        data_out_d  = data_out_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = sp_q[AW-1:0];
        unique case ({push, pop})
            2'b10: begin
                if (full_w) begin
                    overflow_d = 1'b1;
                end else begin
                    wr_en = 1'b1;
                    sp_d  = sp_q + CW'(1);
                end
            end
            2'b01: begin
                if (empty_w) begin
                    underflow_d = 1'b1;
                end else begin
                    data_out_d = mem_q[top_addr];
                    sp_d       = sp_dec;
                end
            end
            2'b11: begin
                // Replace-top keeps sp fixed, so it is legal even when full.
                if (empty_w) begin
                    data_out_d = data_in;
                end else begin
                    data_out_d = mem_q[top_addr];
                    wr_en      = 1'b1;
                    wr_addr    = top_addr;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sp_q        <= '0;
            data_out_q  <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            sp_q        <= sp_d;
            data_out_q  <= data_out_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not cleared by reset; sp alone decides what is visible.
    always_ff @(posedge clk) begin
        if (wr_en && rst) begin
            mem_q[wr_addr] <= data_in;
        end
    end

    assign data_out  = data_out_q;
    assign full      = full_w;
    assign empty     = empty_w;
    assign count     = sp_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_lifo.sv
// Self-checking bench for lifo: a queue-based stack model predicts each edge,
// and words expected on data_out are queued at drive time and popped after the edge.
module tb_lifo;

    localparam int DW = 8;
    localparam int DP = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          push;
    logic          pop;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;
    logic [4:0]    count;
    logic          overflow;
    logic          underflow;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] stk [$];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] m_dout;
    logic          m_ovf;
    logic          m_udf;

    lifo #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .data_in   (data_in),
        .data_out  (data_out),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, predict the outcome, then compare every output after the edge.
    task automatic step(input logic p, input logic q, input logic [DW-1:0] d, input logic rn);
        push    = p;
        pop     = q;
        data_in = d;
        rst     = rn;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        if (!rn) begin
            stk.delete();
            exp_q.delete();
            exp_q.push_back('0);
        end else begin
            case ({p, q})
                2'b10: if (stk.size() == DP) m_ovf = 1'b1; else stk.push_back(d);
                2'b01: if (stk.size() == 0) m_udf = 1'b1; else exp_q.push_back(stk.pop_back());
                2'b11: begin
                    if (stk.size() == 0) begin
                        exp_q.push_back(d);
                    end else begin
                        exp_q.push_back(stk[stk.size()-1]);
                        stk[stk.size()-1] = d;
                    end
                end
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) m_dout = exp_q.pop_front();
        chk("data_out", data_out, m_dout);
        chk("count", count, stk.size());
        chk("empty", empty, stk.size() == 0);
        chk("full", full, stk.size() == DP);
        chk("overflow", overflow, m_ovf);
        chk("underflow", underflow, m_udf);
        push = 1'b0;
        pop  = 1'b0;
        rst  = 1'b1;
    endtask

    initial begin
        push    = 1'b0;
        pop     = 1'b0;
        data_in = '0;
        rst     = 1'b0;
        m_dout  = '0;

        step(0, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);
        chk("rst_dout", data_out, 0);
        chk("rst_empty", empty, 1);

        for (int i = 0; i < 5; i++) step(1, 0, 8'(i), 1);
        chk("push5_count", count, 5);
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 8'h00, 1);
            if (i < 5) chk("pop_seq", data_out, 4 - i);
            if (i == 5) chk("pop6_udf", underflow, 1);
        end
        chk("drain_dout", data_out, 0);

        for (int i = 0; i < 16; i++) step(1, 0, 8'(8'h10 + i), 1);
        chk("fill_full", full, 1);
        chk("fill_count", count, 16);
        step(1, 0, 8'hAA, 1);
        chk("ovf_pulse", overflow, 1);
        chk("ovf_count", count, 16);
        step(0, 1, 8'h00, 1);
        chk("after_ovf_pop", data_out, 8'h1F);
        chk("ovf_clear", overflow, 0);
        step(1, 1, 8'h55, 1);
        chk("full_replace_dout", data_out, 8'h1E);
        step(1, 0, 8'h66, 1);
        step(1, 1, 8'h77, 1);
        chk("replace_no_ovf", overflow, 0);
        chk("replace_full", full, 1);
        while (stk.size() > 0) step(0, 1, 8'h00, 1);

        step(1, 0, 8'h05, 1);
        step(1, 0, 8'h07, 1);
        step(1, 1, 8'h09, 1);
        chk("pp_dout", data_out, 8'h07);
        chk("pp_count", count, 2);
        step(0, 1, 8'h00, 1);
        chk("pp_pop", data_out, 8'h09);
        step(0, 1, 8'h00, 1);
        chk("pp_pop2", data_out, 8'h05);
        step(1, 1, 8'h3C, 1);
        chk("bypass_dout", data_out, 8'h3C);
        chk("bypass_empty", empty, 1);
        chk("bypass_no_udf", underflow, 0);

        step(1, 0, 8'hA1, 1);
        step(1, 0, 8'hA2, 1);
        step(1, 0, 8'hA3, 1);
        step(1, 0, 8'hA4, 0);
        chk("midrst_count", count, 0);
        chk("midrst_dout", data_out, 0);
        step(0, 1, 8'h00, 1);
        chk("midrst_udf", underflow, 1);

        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)), ($urandom_range(0, 49) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lifo.md
# lifo

Synchronous last-in/first-out stack buffer of DEPTH words of DATA_WIDTH bits, used wherever a block needs temporary storage returned in reverse order (e.g. nested-context save/restore). A single clock domain with a synchronous active-low reset. Push and pop are level-sensitive qualifiers sampled every rising edge. The popped word appears on a registered output.

## Interface
- DATA_WIDTH, default 8: width of each stored word.
- DEPTH, default 16: number of storage entries; any integer ≥ 2. Power of two not required.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous and active-low (rst = 0 at a rising edge resets the block).
- push  input  1  write data_in onto top of stack this cycle.
- pop  input  1  remove top of stack and present it on data_out next cycle.
- data_in  input  DATA_WIDTH  word to push.
- data_out  output  DATA_WIDTH  registered; last popped word; holds value otherwise.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  $clog2(DEPTH+1)  current number of stored words.
- overflow  output  1  one-cycle pulse: push rejected because full (without pop).
- underflow  output  1  one-cycle pulse: pop rejected because empty (without push).

## Operation
- Storage: DEPTH-entry register array, plus stack pointer sp = count. Top of stack = mem[sp-1].
- Reset (rst = 0 at edge): sp = 0, data_out = 0, overflow = 0, underflow = 0. Memory contents are not cleared. After reset: empty = 1, full = 0, count = 0.
- Push only (push=1, pop=0):
  - If not full: mem[sp] <= data_in, sp <= sp+1.
  - If full: no write, sp unchanged, overflow <= 1.
- Pop only (pop=1, push=0):
  - If not empty: data_out <= mem[sp-1], sp <= sp-1.
  - If empty: data_out unchanged, sp unchanged, underflow <= 1.
- Push and pop together:
  - If not empty: data_out <= mem[sp-1], mem[sp-1] <= data_in, sp unchanged. This is a replace-top operation and is legal when full; no overflow.
  - If empty: bypass. data_out <= data_in, sp stays 0, no underflow.
- Neither asserted: all state holds; overflow/underflow <= 0.
- overflow/underflow are registered and cleared on every cycle not meeting their condition.
- full, empty and count are combinational decodes of sp (no extra latency).
- No wrap-around: sp saturates at 0 and DEPTH via the rejection rules above.

## Timing
- Push: written word counts toward count/full/empty in the cycle after the edge.
- Pop latency: 1 cycle. Data is on data_out right after the edge at which pop was sampled.
- Back-to-back pops on consecutive cycles yield consecutive words, one per cycle.
- Reset mid-operation: takes priority over push/pop at the same edge. Stack is logically empty the next cycle; stale memory is never observable.
- Inputs must be stable around the rising edge; no handshake beyond full/empty. Sources must gate push on !full and pop on !empty if they need lossless operation. Violations are flagged by the overflow and underflow pulses.

## Test plan
- Reset: hold rst=0 for 2 cycles -> data_out=0, empty=1, full=0, count=0, overflow=underflow=0.
- Push 0,1,2,3,4 on 5 consecutive cycles, then hold pop for 10 cycles -> count goes 5..0. data_out = 4,3,2,1,0 on successive cycles. empty=1 after the fifth pop. The sixth pop pulses underflow and data_out holds 0.
- Push 16 values 0x10..0x1F -> full=1, count=16. A 17th push (0xAA) pulses overflow with count still 16. The next pop returns 0x1F.
- Simultaneous push/pop with stack holding [0x05,0x07] (top 0x07), data_in=0x09 -> data_out=0x07, count=2. A following pop returns 0x09. On an empty stack, data_in=0x3C -> data_out=0x3C, empty stays 1.
- Reset mid-stream: push 3 words, assert rst=0 together with push=1 -> count=0, empty=1, data_out=0. A subsequent pop pulses underflow.
